// File: rtl/ldpc_ber_pkg.sv
// Shared types and status-word field positions for the LDPC BER run sequencer.
package ldpc_ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        STOP_NONE      = 2'd0,
        STOP_TARGET    = 2'd1,
        STOP_ABORT     = 2'd2,
        STOP_ERR_LIMIT = 2'd3
    } stop_reason_e;

    localparam int unsigned STATUS_W          = 32;
    localparam int unsigned STATUS_BITERR_LSB = 0;
    localparam int unsigned STATUS_BITERR_MSB = 15;
    localparam int unsigned STATUS_FERR_BIT   = 31;
    localparam int unsigned BITERR_W          = STATUS_BITERR_MSB - STATUS_BITERR_LSB + 1;

endpackage

// File: rtl/ldpc_ber_sat_acc.sv
// Saturating accumulator with synchronous clear; sticks at all-ones on overflow.
module ldpc_ber_sat_acc #(
    parameter int unsigned CNT_W = 64,
    parameter int unsigned ADD_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [ADD_W-1:0] add_i,
    output logic [CNT_W-1:0] sum_o
);

    logic [CNT_W-1:0] sum_q;
    logic [CNT_W-1:0] sum_d;
    logic [CNT_W:0]   wide_c;

    // Next value: clear wins, otherwise add with carry-out saturation.
    always_comb begin
        wide_c = {1'b0, sum_q} + (CNT_W+1)'(add_i);
        sum_d  = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = wide_c[CNT_W] ? '1 : wide_c[CNT_W-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sum_q <= '0;
        else         sum_q <= sum_d;
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ldpc_ber_run_sequencer.sv
// Run-level sequencer: issues block requests with a bounded number in flight and
// accumulates per-block status. Optional frame-error early stop is built only when
// LDPC_BER_ERR_LIMIT_EN is defined.
module ldpc_ber_run_sequencer
    import ldpc_ber_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [CNT_W-1:0]    target_blocks_i,
    input  logic [CNT_W-1:0]    target_frame_errors_i,
    output logic                ctrl_valid_o,
    input  logic                ctrl_ready_i,
    input  logic                status_valid_i,
    output logic                status_ready_o,
    input  logic [STATUS_W-1:0] status_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          stop_reason_o,
    output logic [CNT_W-1:0]    issued_blocks_o,
    output logic [CNT_W-1:0]    finished_blocks_o,
    output logic [CNT_W-1:0]    bit_errors_o,
    output logic [CNT_W-1:0]    frame_errors_o,
    output logic                protocol_err_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e           state_q,    state_d;
    stop_reason_e     reason_q,   reason_d;
    logic [CNT_W-1:0] issued_q,   issued_d;
    logic [CNT_W-1:0] finished_q, finished_d;
    logic [CNT_W-1:0] frame_q,    frame_d;
    logic [CNT_W-1:0] tgt_blk_q,  tgt_blk_d;
    logic [OUT_W-1:0] outst_q,    outst_d;
    logic             valid_q,    valid_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             perr_q,     perr_d;
    logic             acc_clr,    acc_en;

    logic             hs_ctrl, hs_stat, stat_ok, stat_ferr, pending;
    logic             err_hit, tgt_hit, can_issue;
    logic [CNT_W-1:0] issued_inc, finished_inc, frame_inc;
    logic [OUT_W-1:0] outst_upd;

`ifdef LDPC_BER_ERR_LIMIT_EN
    logic [CNT_W-1:0] tgt_ferr_q, tgt_ferr_d;
    logic             unused_c;
    assign unused_c = ^status_data_i[STATUS_FERR_BIT-1:STATUS_BITERR_MSB+1];
    assign err_hit  = (tgt_ferr_q != '0) && (frame_inc >= tgt_ferr_q);
`else
    logic             unused_c;
    assign unused_c = ^{status_data_i[STATUS_FERR_BIT-1:STATUS_BITERR_MSB+1], target_frame_errors_i};
    assign err_hit  = 1'b0;
`endif

    // Handshakes and post-update counts used for eligibility and stop checks.
    always_comb begin
        hs_ctrl      = valid_q & ctrl_ready_i;
        hs_stat      = busy_q & status_valid_i;
        stat_ok      = hs_stat & (outst_q != '0);
        stat_ferr    = stat_ok & status_data_i[STATUS_FERR_BIT];
        pending      = valid_q & ~ctrl_ready_i;
        issued_inc   = issued_q + CNT_W'(hs_ctrl);
        finished_inc = finished_q + CNT_W'(stat_ok);
        frame_inc    = frame_q + CNT_W'(stat_ferr);
        case ({hs_ctrl, stat_ok})
            2'b10:   outst_upd = outst_q + OUT_W'(1);
            2'b01:   outst_upd = outst_q - OUT_W'(1);
            default: outst_upd = outst_q;
        endcase
        tgt_hit   = issued_inc >= tgt_blk_q;
        can_issue = (issued_inc < tgt_blk_q) && (outst_upd < OUT_W'(MAX_OUTSTANDING));
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        reason_d   = reason_q;
        issued_d   = issued_inc;
        finished_d = finished_inc;
        frame_d    = frame_inc;
        outst_d    = outst_upd;
        tgt_blk_d  = tgt_blk_q;
        perr_d     = perr_q | (hs_stat & (outst_q == '0));
        valid_d    = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = stat_ok;
`ifdef LDPC_BER_ERR_LIMIT_EN
        tgt_ferr_d = tgt_ferr_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    issued_d   = '0;
                    finished_d = '0;
                    frame_d    = '0;
                    outst_d    = '0;
                    perr_d     = 1'b0;
                    acc_clr    = 1'b1;
                    tgt_blk_d  = target_blocks_i;
`ifdef LDPC_BER_ERR_LIMIT_EN
                    tgt_ferr_d = target_frame_errors_i;
`endif
                    if (target_blocks_i == '0) begin
                        state_d  = ST_DONE;
                        reason_d = STOP_TARGET;
                    end else begin
                        state_d  = ST_RUN;
                        reason_d = STOP_NONE;
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (reason_q == STOP_NONE) begin
                    if (abort_i)      reason_d = STOP_ABORT;
                    else if (err_hit) reason_d = STOP_ERR_LIMIT;
                    else if (tgt_hit) reason_d = STOP_TARGET;
                end
                // A request already on the bus is never withdrawn.
                valid_d = pending | ((reason_d == STOP_NONE) & can_issue);
                if ((reason_d != STOP_NONE) && !valid_d) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outst_upd == '0) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            reason_q   <= STOP_NONE;
            issued_q   <= '0;
            finished_q <= '0;
            frame_q    <= '0;
            tgt_blk_q  <= '0;
            outst_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
`ifdef LDPC_BER_ERR_LIMIT_EN
            tgt_ferr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            reason_q   <= reason_d;
            issued_q   <= issued_d;
            finished_q <= finished_d;
            frame_q    <= frame_d;
            tgt_blk_q  <= tgt_blk_d;
            outst_q    <= outst_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
`ifdef LDPC_BER_ERR_LIMIT_EN
            tgt_ferr_q <= tgt_ferr_d;
`endif
        end
    end

    ldpc_ber_sat_acc #(
        .CNT_W (CNT_W),
        .ADD_W (BITERR_W)
    ) u_bit_acc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .add_i   (status_data_i[STATUS_BITERR_MSB:STATUS_BITERR_LSB]),
        .sum_o   (bit_errors_o)
    );

    assign ctrl_valid_o      = valid_q;
    assign status_ready_o    = busy_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign stop_reason_o     = reason_q;
    assign issued_blocks_o   = issued_q;
    assign finished_blocks_o = finished_q;
    assign frame_errors_o    = frame_q;
    assign protocol_err_o    = perr_q;

endmodule

// File: tb/tb_ldpc_ber_run_sequencer.sv
// Directed bench for ldpc_ber_run_sequencer with a 3-cycle-latency datapath stand-in.
module tb_ldpc_ber_run_sequencer;

    localparam int unsigned MAXO = 4;
    localparam int unsigned CW   = 20;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic          abort_i;
    logic [CW-1:0] target_blocks_i;
    logic [CW-1:0] target_frame_errors_i;
    logic          ctrl_valid_o;
    logic          ctrl_ready_i;
    logic          status_valid_i;
    logic          status_ready_o;
    logic [31:0]   status_data_i;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    stop_reason_o;
    logic [CW-1:0] issued_blocks_o;
    logic [CW-1:0] finished_blocks_o;
    logic [CW-1:0] bit_errors_o;
    logic [CW-1:0] frame_errors_o;
    logic          protocol_err_o;

    int        n_cmp;
    int        n_fail;
    int        cyc;
    int        hs_cnt;
    int        beat_cnt;
    int        max_out;
    int        due_q[$];
    bit        rsp_en;
    logic [15:0] bits_val;
    int        ferr_a;
    int        ferr_b;

    always #5 clk = ~clk;

    ldpc_ber_run_sequencer #(
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CW)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .start_i               (start_i),
        .abort_i               (abort_i),
        .target_blocks_i       (target_blocks_i),
        .target_frame_errors_i (target_frame_errors_i),
        .ctrl_valid_o          (ctrl_valid_o),
        .ctrl_ready_i          (ctrl_ready_i),
        .status_valid_i        (status_valid_i),
        .status_ready_o        (status_ready_o),
        .status_data_i         (status_data_i),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .stop_reason_o         (stop_reason_o),
        .issued_blocks_o       (issued_blocks_o),
        .finished_blocks_o     (finished_blocks_o),
        .bit_errors_o          (bit_errors_o),
        .frame_errors_o        (frame_errors_o),
        .protocol_err_o        (protocol_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes at the negedge, then drive the next cycle's inputs.
    task automatic tick();
        @(negedge clk);
        if (ctrl_valid_o && ctrl_ready_i) begin
            hs_cnt++;
            due_q.push_back(cyc + 3);
        end
        if (rsp_en && status_valid_i && status_ready_o) begin
            beat_cnt++;
            void'(due_q.pop_front());
        end
        if (hs_cnt - beat_cnt > max_out) max_out = hs_cnt - beat_cnt;
        @(posedge clk);
        #1;
        cyc++;
        start_i = 1'b0;
        abort_i = 1'b0;
        if (rsp_en) begin
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                status_valid_i = 1'b1;
                status_data_i  = {((beat_cnt + 1 == ferr_a) || (beat_cnt + 1 == ferr_b)), 15'd0, bits_val};
            end else begin
                status_valid_i = 1'b0;
                status_data_i  = '0;
            end
        end
    endtask

    task automatic clear_model();
        hs_cnt   = 0;
        beat_cnt = 0;
        max_out  = 0;
        due_q.delete();
    endtask

    task automatic run_to_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_o), 64'd1);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        target_blocks_i = '0; target_frame_errors_i = '0;
        ctrl_ready_i = 1'b0; status_valid_i = 1'b0; status_data_i = '0;
        rsp_en = 1'b0; bits_val = '0; ferr_a = 0; ferr_b = 0;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  64'(ctrl_valid_o),    64'd0);
        chk("rst_sready", 64'(status_ready_o),  64'd0);
        chk("rst_busy",   64'(busy_o),          64'd0);
        chk("rst_done",   64'(done_o),          64'd0);
        chk("rst_reason", 64'(stop_reason_o),   64'd0);
        chk("rst_issued", 64'(issued_blocks_o), 64'd0);
        chk("rst_biterr", 64'(bit_errors_o),    64'd0);
        reset_i = 1'b0;
        tick();

        // Ten blocks, ready always high, status after 3 cycles, 3 bit errors each
        clear_model();
        target_blocks_i = CW'(10); ctrl_ready_i = 1'b1; rsp_en = 1'b1; bits_val = 16'd3;
        start_i = 1'b1;
        tick();
        chk("t1_valid_n1",  64'(ctrl_valid_o),   64'd1);
        chk("t1_busy_n1",   64'(busy_o),         64'd1);
        chk("t1_sready_n1", 64'(status_ready_o), 64'd1);
        run_to_done("t1_done");
        chk("t1_hs",       64'(hs_cnt),            64'd10);
        chk("t1_maxout",   64'(max_out <= 4),      64'd1);
        chk("t1_reason",   64'(stop_reason_o),     64'd1);
        chk("t1_issued",   64'(issued_blocks_o),   64'd10);
        chk("t1_finished", 64'(finished_blocks_o), 64'd10);
        chk("t1_biterr",   64'(bit_errors_o),      64'd30);
        chk("t1_frame",    64'(frame_errors_o),    64'd0);
        chk("t1_busy",     64'(busy_o),            64'd0);
        repeat (2) tick();
        chk("t1_hold_issued", 64'(issued_blocks_o), 64'd10);
        chk("t1_hold_done",   64'(done_o),          64'd1);

        // Zero target goes straight to DONE
        clear_model();
        target_blocks_i = '0;
        start_i = 1'b1;
        tick();
        chk("t2_done",   64'(done_o),          64'd1);
        chk("t2_reason", 64'(stop_reason_o),   64'd1);
        chk("t2_valid",  64'(ctrl_valid_o),    64'd0);
        chk("t2_issued", 64'(issued_blocks_o), 64'd0);
        chk("t2_biterr", 64'(bit_errors_o),    64'd0);
        repeat (2) tick();
        chk("t2_hs", 64'(hs_cnt), 64'd0);

        // Abort while a request is stalled: request completes, then drain
        clear_model();
        target_blocks_i = CW'(10); ctrl_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        chk("t3_valid", 64'(ctrl_valid_o), 64'd1);
        tick();
        abort_i = 1'b1;
        tick();
        chk("t3_valid_held", 64'(ctrl_valid_o),  64'd1);
        chk("t3_reason_ab",  64'(stop_reason_o), 64'd2);
        chk("t3_busy",       64'(busy_o),        64'd1);
        repeat (2) tick();
        chk("t3_valid_held2", 64'(ctrl_valid_o), 64'd1);
        ctrl_ready_i = 1'b1;
        tick();
        chk("t3_valid_drop", 64'(ctrl_valid_o),    64'd0);
        chk("t3_issued1",    64'(issued_blocks_o), 64'd1);
        run_to_done("t3_done");
        chk("t3_reason",   64'(stop_reason_o),     64'd2);
        chk("t3_finished", 64'(finished_blocks_o), 64'd1);
        chk("t3_hs",       64'(hs_cnt),            64'd1);
        chk("t3_perr",     64'(protocol_err_o),    64'd0);

        // Frame errors on blocks 3 and 5 with a threshold of 2
        clear_model();
        bits_val = '0; ferr_a = 3; ferr_b = 5;
        target_frame_errors_i = CW'(2);
`ifdef LDPC_BER_ERR_LIMIT_EN
        target_blocks_i = CW'(100);
        start_i = 1'b1;
        tick();
        run_to_done("t4_done");
        chk("t4_reason",   64'(stop_reason_o),                       64'd3);
        chk("t4_frame",    64'(frame_errors_o),                      64'd2);
        chk("t4_issued",   64'(issued_blocks_o),                     64'(hs_cnt));
        chk("t4_finished", 64'(finished_blocks_o),                   64'(beat_cnt));
        chk("t4_early",    64'(issued_blocks_o < CW'(100)),          64'd1);
        chk("t4_drained",  64'(issued_blocks_o == finished_blocks_o), 64'd1);
`else
        target_blocks_i = CW'(6);
        start_i = 1'b1;
        tick();
        run_to_done("t4_done");
        chk("t4_reason", 64'(stop_reason_o),   64'd1);
        chk("t4_frame",  64'(frame_errors_o),  64'd2);
        chk("t4_issued", 64'(issued_blocks_o), 64'd6);
`endif
        ferr_a = 0; ferr_b = 0; target_frame_errors_i = '0;

        // bit_errors saturation: 20 x 0xFFFF exceeds a 20-bit counter
        clear_model();
        target_blocks_i = CW'(20); bits_val = 16'hFFFF;
        start_i = 1'b1;
        tick();
        run_to_done("t5_done");
        chk("t5_biterr",   64'(bit_errors_o),      64'h000F_FFFF);
        chk("t5_finished", 64'(finished_blocks_o), 64'd20);
        chk("t5_reason",   64'(stop_reason_o),     64'd1);
        chk("t5_frame",    64'(frame_errors_o),    64'd0);

        // Spurious status beat with nothing outstanding
        clear_model();
        rsp_en = 1'b0; ctrl_ready_i = 1'b0; bits_val = '0;
        status_valid_i = 1'b0; status_data_i = '0;
        target_blocks_i = CW'(5);
        start_i = 1'b1;
        tick();
        chk("t6_valid", 64'(ctrl_valid_o), 64'd1);
        status_valid_i = 1'b1; status_data_i = 32'h8000_0007;
        tick();
        status_valid_i = 1'b0; status_data_i = '0;
        tick();
        chk("t6_perr",     64'(protocol_err_o),    64'd1);
        chk("t6_finished", 64'(finished_blocks_o), 64'd0);
        chk("t6_biterr",   64'(bit_errors_o),      64'd0);
        chk("t6_frame",    64'(frame_errors_o),    64'd0);

        // Asynchronous reset mid-run, checked before the next clock edge
        reset_i = 1'b1;
        #2;
        chk("t6_rst_valid",  64'(ctrl_valid_o),   64'd0);
        chk("t6_rst_busy",   64'(busy_o),         64'd0);
        chk("t6_rst_perr",   64'(protocol_err_o), 64'd0);
        chk("t6_rst_sready", 64'(status_ready_o), 64'd0);
        chk("t6_rst_reason", 64'(stop_reason_o),  64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
